rv_muldiv: RTL and testbench

Iterative multiply/divide unit implementing the RV32M/RV64M arithmetic (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the pipelined core. It sits beside the ALU in the Execute stage. The core's control drives it with the decoded funct3 and operands and stalls Fetch/Decode/Execute while `busy` is high. Width is parametrised so the same unit serves 32- and 64-bit cores.

---
 rtl/rv_pkg.sv | 48 ++++
 rtl/rv_muldiv.sv | 191 +++++++++++++++++++
 tb/tb_rv_muldiv.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// operation and state encodings plus small decode helpers.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Operation select, encoded exactly as the instruction funct3 field.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_signed_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rv_muldiv.sv
// Iterative multiply/divide unit for the Execute stage.
// Multiplies with a radix-2 shift-add and divides with a restoring divider,
// both on operand magnitudes over exactly XLEN cycles, then fixes the sign in
// a single FIX cycle. Divide-by-zero and signed overflow are resolved at the
// accept edge without iterating.
//
// Handshake: a request is taken on a rising edge where start=1, flush=0 and
// the unit is IDLE. busy is high from the cycle after acceptance until the
// unit is IDLE again; done pulses for one cycle with result valid. start is
// ignored whenever the unit is not IDLE; flush returns the unit to IDLE at
// the next edge without a done pulse and without touching result.
module rv_muldiv
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output muldiv_state_e   dbg_state
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);

  // Architectural and datapath registers.
  muldiv_state_e      state_q;
  muldiv_op_e         op_q;
  logic               neg_res_q;   // product / quotient needs negating
  logic               neg_rem_q;   // remainder needs negating (dividend < 0)
  logic [XLEN-1:0]    b_q;         // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]  acc_q;       // {hi, lo}: product, or {remainder, quotient}
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [XLEN-1:0]    result_q;

  // Request decode.
  muldiv_op_e         op_in;
  logic               neg_a_in;
  logic               neg_b_in;
  logic [XLEN-1:0]    mag_a_in;
  logic [XLEN-1:0]    mag_b_in;
  logic               div_zero;
  logic               div_ovf;
  logic [XLEN-1:0]    special_res;

  // Iteration datapath.
  logic [XLEN:0]      mul_sum;
  logic [2*XLEN-1:0]  mul_next;
  logic [2*XLEN:0]    div_shift;
  logic [XLEN:0]      div_trial;
  logic               div_ge;
  logic [XLEN-1:0]    div_rem_next;
  logic [2*XLEN-1:0]  div_next;
  logic [2*XLEN-1:0]  acc_step;

  // Sign fix-up datapath.
  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN-1:0]    quo_fix;
  logic [XLEN-1:0]    rem_fix;
  logic [XLEN-1:0]    fix_word;

  assign op_in = muldiv_op_e'(funct3);

  // Decode the incoming request into operand signs, magnitudes and special cases.
  always_comb begin
    neg_a_in = op_a_signed(op_in) & op_a[XLEN-1];
    neg_b_in = op_b_signed(op_in) & op_b[XLEN-1];
    mag_a_in = neg_a_in ? (~op_a + 1'b1) : op_a;
    mag_b_in = neg_b_in ? (~op_b + 1'b1) : op_b;
    div_zero = op_is_div(op_in) && (op_b == '0);
    div_ovf  = op_is_signed_div(op_in) && (op_a == MOST_NEG) && (op_b == '1);
    special_res = '1;
    if (div_zero) begin
      special_res = op_is_rem(op_in) ? op_a : '1;
    end else begin
      special_res = op_is_rem(op_in) ? '0 : op_a;
    end
  end

  // One iteration: shift-add for multiply, restoring trial subtract for divide.
  always_comb begin
    // Multiply: add the multiplicand into the high half when the current
    // multiplier bit (acc lsb) is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: shift {remainder, dividend} left; the top XLEN+1 bits form the
    // trial remainder, which can momentarily exceed XLEN bits.
    div_shift    = {acc_q, 1'b0};
    div_trial    = div_shift[2*XLEN:XLEN];
    div_ge       = (div_trial >= {1'b0, b_q});
    div_rem_next = div_ge ? XLEN'(div_trial - {1'b0, b_q}) : div_trial[XLEN-1:0];
    div_next     = {div_rem_next, div_shift[XLEN-1:1], div_ge};
    acc_step     = op_is_div(op_q) ? div_next : mul_next;
  end

  // Apply result signs and pick the architectural word.
  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    fix_word = '0;
    case (op_q)
      OP_MUL:                      fix_word = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_word = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_word = quo_fix;
      OP_REM, OP_REMU:             fix_word = rem_fix;
      default:                     fix_word = '0;
    endcase
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q      <= op_in;
            neg_res_q <= neg_a_in ^ neg_b_in;
            neg_rem_q <= neg_a_in;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (div_zero || div_ovf) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              b_q     <= mag_b_in;
              acc_q   <= {{XLEN{1'b0}}, mag_a_in};
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q <= fix_word;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Self-checking bench for rv_muldiv: one 32-bit and one 64-bit instance,
// directed cases, randomized ops against an arithmetic reference model,
// flush/reset mid-operation and back-to-back requests.
module tb_rv_muldiv;
  import rv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          start32, flush32, busy32, done32;
  logic [2:0]    f3_32;
  logic [31:0]   a32, b32, res32;
  muldiv_state_e st32;

  logic          start64, flush64, busy64, done64;
  logic [2:0]    f3_64;
  logic [63:0]   a64, b64, res64;
  muldiv_state_e st64;

  int n_checks = 0;
  int n_fail   = 0;

  rv_muldiv #(.XLEN(32)) dut32 (
    .clk(clk), .reset(rst_n), .start(start32), .funct3(f3_32), .op_a(a32), .op_b(b32),
    .flush(flush32), .busy(busy32), .done(done32), .result(res32), .dbg_state(st32)
  );

  rv_muldiv #(.XLEN(64)) dut64 (
    .clk(clk), .reset(rst_n), .start(start64), .funct3(f3_64), .op_a(a64), .op_b(b64),
    .flush(flush64), .busy(busy64), .done(done64), .result(res64), .dbg_state(st64)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic [63:0] a_in,
                                            input logic [63:0] b_in, input int xl);
    logic [63:0] mask, a, b;
    logic signed [129:0] sa, sb, ua, ub, p;
    mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    a = a_in & mask;
    b = b_in & mask;
    ua = {66'b0, a};
    ub = {66'b0, b};
    if (xl == 32) begin
      sa = {{98{a[31]}}, a[31:0]};
      sb = {{98{b[31]}}, b[31:0]};
    end else begin
      sa = {{66{a[63]}}, a};
      sb = {{66{b[63]}}, b};
    end
    p = '0;
    case (f3)
      3'b000: begin p = ua * ub; return p[63:0] & mask; end
      3'b001: begin p = sa * sb; return 64'(p >>> xl) & mask; end
      3'b010: begin p = sa * ub; return 64'(p >>> xl) & mask; end
      3'b011: begin p = ua * ub; return 64'(p >>> xl) & mask; end
      3'b100: begin if (b == 0) return mask; p = sa / sb; return p[63:0] & mask; end
      3'b101: begin if (b == 0) return mask; p = ua / ub; return p[63:0] & mask; end
      3'b110: begin if (b == 0) return a;    p = sa % sb; return p[63:0] & mask; end
      default: begin if (b == 0) return a;   p = ua % ub; return p[63:0] & mask; end
    endcase
  endfunction

  // Cycle (1-based after the accept edge) in which done is expected.
  function automatic int exp_lat(input logic [2:0] f3, input logic [63:0] a_in,
                                 input logic [63:0] b_in, input int xl);
    logic [63:0] mask, mn, a, b;
    mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    mn   = 64'h1 << (xl - 1);
    a = a_in & mask;
    b = b_in & mask;
    if (f3[2] && ((b == 0) || (!f3[0] && a == mn && b == mask))) return 1;
    return xl + 2;
  endfunction

  function automatic logic [63:0] pick_operand(input int xl);
    logic [63:0] v, mask;
    mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    case ($urandom_range(0, 5))
      0: v = {$urandom, $urandom};
      1: v = 64'($urandom_range(0, 20));
      2: v = '0;
      3: v = '1;
      4: v = 64'h1 << (xl - 1);
      default: v = 64'(0) - 64'($urandom_range(1, 20));
    endcase
    return v & mask;
  endfunction

  // ---------------- driver ----------------
  // Issues one request and observes until busy falls (bounded).
  task automatic run_op(input bit w64, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int done_cyc,
                        output int done_cnt, output int busy_cnt);
    int xl;
    logic cb, cd;
    xl = w64 ? 64 : 32;
    res = '0; done_cyc = 0; done_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    if (w64) begin
      start64 = 1'b1; f3_64 = f3; a64 = a; b64 = b;
    end else begin
      start32 = 1'b1; f3_32 = f3; a32 = a[31:0]; b32 = b[31:0];
    end
    for (int n = 1; n <= xl + 6; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin start32 = 1'b0; start64 = 1'b0; end
      cb = w64 ? busy64 : busy32;
      cd = w64 ? done64 : done32;
      if (cb) busy_cnt++;
      if (cd) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = n;
          res = w64 ? res64 : {32'b0, res32};
        end
      end
      if (!cb) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset busy32: got %b expected 0", busy32); end
    n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL reset done32: got %b expected 0", done32); end
    n_checks++; if (res32 !== 32'h0) begin n_fail++; $display("FAIL reset result32: got %h expected 0", res32); end
    n_checks++; if (st32 !== ST_IDLE) begin n_fail++; $display("FAIL reset state32: got %0d expected IDLE", st32); end
    n_checks++; if (busy64 !== 1'b0) begin n_fail++; $display("FAIL reset busy64: got %b expected 0", busy64); end
    n_checks++; if (res64 !== 64'h0) begin n_fail++; $display("FAIL reset result64: got %h expected 0", res64); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed32();
    logic [2:0]  f3_t [12] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                               3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] a_t  [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] b_t  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e_t  [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int          l_t  [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
    logic [63:0] r;
    int dc, dn, bc;
    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, f3_t[i], {32'b0, a_t[i]}, {32'b0, b_t[i]}, r, dc, dn, bc);
      n_checks++; if (r[31:0] !== e_t[i]) begin n_fail++; $display("FAIL dir32[%0d] result: got %h expected %h", i, r[31:0], e_t[i]); end
      n_checks++; if (dc !== l_t[i]) begin n_fail++; $display("FAIL dir32[%0d] done cycle: got %0d expected %0d", i, dc, l_t[i]); end
      n_checks++; if (bc !== l_t[i]) begin n_fail++; $display("FAIL dir32[%0d] busy cycles: got %0d expected %0d", i, bc, l_t[i]); end
      n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL dir32[%0d] done pulses: got %0d expected 1", i, dn); end
    end
  endtask

  task automatic test_directed64();
    logic [2:0]  f3_t [4] = '{3'b000, 3'b011, 3'b100, 3'b110};
    logic [63:0] a_t  [4] = '{64'd7, '1, 64'hFFFFFFFF_FFFFFFF9, 64'hFFFFFFFF_FFFFFFF9};
    logic [63:0] b_t  [4] = '{64'hFFFFFFFF_FFFFFFFD, '1, 64'd2, 64'd2};
    logic [63:0] e_t  [4] = '{64'hFFFFFFFF_FFFFFFEB, 64'hFFFFFFFF_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFD, '1};
    logic [63:0] r;
    int dc, dn, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, f3_t[i], a_t[i], b_t[i], r, dc, dn, bc);
      n_checks++; if (r !== e_t[i]) begin n_fail++; $display("FAIL dir64[%0d] result: got %h expected %h", i, r, e_t[i]); end
      n_checks++; if (dc !== 66) begin n_fail++; $display("FAIL dir64[%0d] done cycle: got %0d expected 66", i, dc); end
      n_checks++; if (bc !== 66) begin n_fail++; $display("FAIL dir64[%0d] busy cycles: got %0d expected 66", i, bc); end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, r, e;
    logic [2:0]  f3;
    bit          w64;
    int xl, dc, dn, bc, l;
    for (int i = 0; i < 36; i++) begin
      w64 = (i % 3 == 2);
      xl  = w64 ? 64 : 32;
      f3  = 3'($urandom_range(0, 7));
      a   = pick_operand(xl);
      b   = pick_operand(xl);
      e   = ref_model(f3, a, b, xl);
      l   = exp_lat(f3, a, b, xl);
      run_op(w64, f3, a, b, r, dc, dn, bc);
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL rand[%0d] x%0d f3=%0d a=%h b=%h result: got %h expected %h", i, xl, f3, a, b, r, e); end
      n_checks++; if (dc !== l) begin n_fail++; $display("FAIL rand[%0d] done cycle: got %0d expected %0d", i, dc, l); end
      n_checks++; if (bc !== l) begin n_fail++; $display("FAIL rand[%0d] busy cycles: got %0d expected %0d", i, bc, l); end
    end
  endtask

  task automatic test_flush();
    logic [63:0] r;
    int dc, dn, bc, seen;
    run_op(1'b0, 3'b101, 64'd100, 64'd7, r, dc, dn, bc);
    n_checks++; if (r[31:0] !== 32'd14) begin n_fail++; $display("FAIL flush setup result: got %h expected %h", r[31:0], 32'd14); end
    @(negedge clk);
    start32 = 1'b1; f3_32 = 3'b000; a32 = 32'h1234; b32 = 32'h5678;
    seen = 0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (n == 1) start32 = 1'b0;
      if (done32) seen++;
      if (n == 10) begin
        n_checks++; if (busy32 !== 1'b1) begin n_fail++; $display("FAIL flush pre busy: got %b expected 1", busy32); end
        flush32 = 1'b1;
      end
      if (n == 11) begin
        flush32 = 1'b0;
        n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL flush busy: got %b expected 0", busy32); end
        n_checks++; if (st32 !== ST_IDLE) begin n_fail++; $display("FAIL flush state: got %0d expected IDLE", st32); end
      end
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush done pulses: got %0d expected 0", seen); end
    n_checks++; if (res32 !== 32'd14) begin n_fail++; $display("FAIL flush result kept: got %h expected %h", res32, 32'd14); end
    // start together with flush in IDLE must not be accepted
    @(negedge clk);
    start32 = 1'b1; flush32 = 1'b1; f3_32 = 3'b101; a32 = 32'd5; b32 = 32'd0;
    @(posedge clk); #1;
    start32 = 1'b0; flush32 = 1'b0;
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL flush+start busy: got %b expected 0", busy32); end
    n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL flush+start done: got %b expected 0", done32); end
  endtask

  task automatic test_reset_midop();
    logic [63:0] r;
    int dc, dn, bc, seen;
    @(negedge clk);
    start32 = 1'b1; f3_32 = 3'b100; a32 = 32'd1000; b32 = 32'd3;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) start32 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b expected 0", busy32); end
    n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL midreset done: got %b expected 0", done32); end
    n_checks++; if (res32 !== 32'h0) begin n_fail++; $display("FAIL midreset result: got %h expected 0", res32); end
    n_checks++; if (st32 !== ST_IDLE) begin n_fail++; $display("FAIL midreset state: got %0d expected IDLE", st32); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done32) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset done pulses: got %0d expected 0", seen); end
    run_op(1'b0, 3'b000, 64'd3, 64'd4, r, dc, dn, bc);
    n_checks++; if (r[31:0] !== 32'd12) begin n_fail++; $display("FAIL midreset mul result: got %h expected %h", r[31:0], 32'd12); end
    n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL midreset mul done cycle: got %0d expected 34", dc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] e1, e2;
    logic [31:0] r1, r2;
    int d1, d2, idle, l1, l2;
    a1 = $urandom; b1 = 32'($urandom_range(1, 1000));
    a2 = $urandom; b2 = $urandom;
    e1 = ref_model(3'b100, {32'b0, a1}, {32'b0, b1}, 32);
    e2 = ref_model(3'b010, {32'b0, a2}, {32'b0, b2}, 32);
    l1 = exp_lat(3'b100, {32'b0, a1}, {32'b0, b1}, 32);
    l2 = exp_lat(3'b010, {32'b0, a2}, {32'b0, b2}, 32);
    r1 = '0; r2 = '0; d1 = 0; d2 = 0; idle = 0;
    @(negedge clk);
    start32 = 1'b1; f3_32 = 3'b100; a32 = a1; b32 = b1;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin f3_32 = 3'b010; a32 = a2; b32 = b2; end
      if (done32) begin
        if (d1 == 0) begin d1 = n; r1 = res32; end
        else if (d2 == 0) begin d2 = n; r2 = res32; end
      end
      if (!busy32 && idle == 0 && n > 1) idle = n;
      if (idle != 0 && n == idle + 1) start32 = 1'b0;
      if (d2 != 0 && !busy32) break;
    end
    start32 = 1'b0;
    n_checks++; if (r1 !== e1[31:0]) begin n_fail++; $display("FAIL b2b first result: got %h expected %h", r1, e1[31:0]); end
    n_checks++; if (d1 !== l1) begin n_fail++; $display("FAIL b2b first done cycle: got %0d expected %0d", d1, l1); end
    n_checks++; if (idle !== l1 + 1) begin n_fail++; $display("FAIL b2b idle cycle: got %0d expected %0d", idle, l1 + 1); end
    n_checks++; if (r2 !== e2[31:0]) begin n_fail++; $display("FAIL b2b second result: got %h expected %h", r2, e2[31:0]); end
    n_checks++; if (d2 !== l1 + 1 + l2) begin n_fail++; $display("FAIL b2b second done cycle: got %0d expected %0d", d2, l1 + 1 + l2); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    start32 = 1'b0; flush32 = 1'b0; f3_32 = '0; a32 = '0; b32 = '0;
    start64 = 1'b0; flush64 = 1'b0; f3_64 = '0; a64 = '0; b64 = '0;
    test_reset();
    test_directed32();
    test_directed64();
    test_random();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
